// File: rtl/axis_xbar_pkg.sv
// Shared types and helpers for the AXI-Stream mode crossbar.
// Ingress FSM encoding and destination code sizing.
package axis_xbar_pkg;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_REQ,
    IN_FWD,
    IN_DROP
  } in_state_e;

  localparam int unsigned N_OUT_DEF = 4;
  localparam int unsigned DEST_DROP = N_OUT_DEF;

  function automatic int unsigned dest_bits(
    input int unsigned n_out
  );
    return $clog2(n_out + 1);
  endfunction

  function automatic int unsigned dest_drop(
    input int unsigned n_out
  );
    return n_out;
  endfunction

  function automatic int unsigned idx_bits(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Per-egress owner register with round-robin packet grant.
// A release and a new grant may happen in the same cycle.
module axis_rr_arbiter
  import axis_xbar_pkg::*;
#(
  parameter int unsigned N_IN = 4,
  parameter int unsigned IW   = idx_bits(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] req,
  input  logic            rel,
  output logic [N_IN-1:0] gnt,
  output logic            busy,
  output logic [IW-1:0]   owner
);

  logic          busy_q, busy_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          hit;
  logic [IW-1:0] pick;
  int unsigned   j;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    hit  = 1'b0;
    pick = '0;
    j    = 0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      j = (32'(ptr_q) + k) % N_IN;
      if (!hit && req[j]) begin
        hit  = 1'b1;
        pick = IW'(j);
      end
    end
  end

  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt     = '0;
    if (busy_q && rel) begin
      busy_d = 1'b0;
    end
    if ((!busy_q || rel) && hit) begin
      busy_d    = 1'b1;
      owner_d   = pick;
      ptr_d     = IW'((32'(pick) + 1) % N_IN);
      gnt[pick] = 1'b1;
    end
  end

  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: rtl/axis_mode_crossbar.sv
// N_IN x N_OUT AXI-Stream packet router with per-packet routing,
// round-robin egress sharing and per-egress packet counters.
module axis_mode_crossbar
  import axis_xbar_pkg::*;
#(
  parameter int unsigned N_IN      = 4,
  parameter int unsigned N_OUT     = 4,
  parameter int unsigned DATA_BITS = 512,
  parameter int unsigned ID_BITS   = 6,
  parameter int unsigned DEST_BITS = dest_bits(N_OUT),
  parameter int unsigned CNT_BITS  = 32
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [N_IN-1:0]              s_tvalid,
  output logic [N_IN-1:0]              s_tready,
  input  logic [N_IN*DATA_BITS-1:0]    s_tdata,
  input  logic [N_IN*DATA_BITS/8-1:0]  s_tkeep,
  input  logic [N_IN*ID_BITS-1:0]      s_tid,
  input  logic [N_IN-1:0]              s_tlast,
  output logic [N_OUT-1:0]             m_tvalid,
  input  logic [N_OUT-1:0]             m_tready,
  output logic [N_OUT*DATA_BITS-1:0]   m_tdata,
  output logic [N_OUT*DATA_BITS/8-1:0] m_tkeep,
  output logic [N_OUT*ID_BITS-1:0]     m_tid,
  output logic [N_OUT-1:0]             m_tlast,
  input  logic [N_IN*DEST_BITS-1:0]    cfg_dest,
  input  logic [N_IN-1:0]              cfg_en,
  input  logic                         cnt_clr,
  output logic [N_OUT*CNT_BITS-1:0]    pkt_cnt,
  output logic [CNT_BITS-1:0]          drop_cnt
);

  localparam int unsigned KB   = DATA_BITS / 8;
  localparam int unsigned IW   = idx_bits(N_IN);
  localparam int unsigned DROP = dest_drop(N_OUT);

  in_state_e            st_q   [N_IN];
  in_state_e            st_d   [N_IN];
  logic [DEST_BITS-1:0] dest_q [N_IN];
  logic [DEST_BITS-1:0] dest_d [N_IN];
  logic [N_IN-1:0]      to_drop;
  logic [N_IN-1:0]      granted;
  logic [N_IN-1:0]      req    [N_OUT];
  logic [N_IN-1:0]      gnt    [N_OUT];
  logic [IW-1:0]        owner  [N_OUT];
  logic [N_OUT-1:0]     busy;
  logic [N_OUT-1:0]     rel;
  logic [CNT_BITS-1:0]  pkt_q  [N_OUT];
  logic [CNT_BITS-1:0]  pkt_d  [N_OUT];
  logic [CNT_BITS-1:0]  drop_q, drop_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        st_q[i]   <= IN_IDLE;
        dest_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        st_q[i]   <= st_d[i];
        dest_q[i] <= dest_d[i];
      end
    end
  end

  // Route decode and grant fan-in from the egress arbiters.
  always_comb begin
    to_drop = '0;
    granted = '0;
    for (int unsigned o = 0; o < N_OUT; o++) begin
      req[o] = '0;
    end
    for (int unsigned i = 0; i < N_IN; i++) begin
      to_drop[i] = 32'(dest_q[i]) >= DROP;
      for (int unsigned o = 0; o < N_OUT; o++) begin
        if (st_q[i] == IN_REQ && !to_drop[i] &&
            32'(dest_q[i]) == o) begin
          req[o][i] = 1'b1;
        end
        if (gnt[o][i]) begin
          granted[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_IN; i++) begin
      st_d[i]   = st_q[i];
      dest_d[i] = dest_q[i];
      unique case (st_q[i])
        IN_IDLE: begin
          if (s_tvalid[i] && cfg_en[i]) begin
            st_d[i]   = IN_REQ;
            dest_d[i] = cfg_dest[i*DEST_BITS +: DEST_BITS];
          end
        end
        IN_REQ: begin
          if (to_drop[i]) begin
            st_d[i] = IN_DROP;
          end else if (granted[i]) begin
            st_d[i] = IN_FWD;
          end
        end
        IN_FWD, IN_DROP: begin
          if (s_tvalid[i] && s_tready[i] && s_tlast[i]) begin
            st_d[i] = IN_IDLE;
          end
        end
        default: st_d[i] = IN_IDLE;
      endcase
    end
  end

  always_comb begin
    s_tready = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      unique case (1'b1)
        st_q[i] == IN_FWD: begin
          for (int unsigned o = 0; o < N_OUT; o++) begin
            if (32'(dest_q[i]) == o) begin
              s_tready[i] = m_tready[o];
            end
          end
        end
        st_q[i] == IN_DROP: s_tready[i] = 1'b1;
        default:            s_tready[i] = 1'b0;
      endcase
    end
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_arb
    axis_rr_arbiter #(
      .N_IN (N_IN)
    ) u_arb (
      .clk   (aclk),
      .rst_n (aresetn),
      .req   (req[o]),
      .rel   (rel[o]),
      .gnt   (gnt[o]),
      .busy  (busy[o]),
      .owner (owner[o])
    );
  end

  // Unregistered path from the owning ingress to its egress.
  always_comb begin
    m_tvalid = '0;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tid    = '0;
    m_tlast  = '0;
    for (int unsigned o = 0; o < N_OUT; o++) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (busy[o] && 32'(owner[o]) == i) begin
          m_tvalid[o] = s_tvalid[i];
          m_tlast[o]  = s_tlast[i];
          m_tdata[o*DATA_BITS +: DATA_BITS] =
            s_tdata[i*DATA_BITS +: DATA_BITS];
          m_tkeep[o*KB +: KB] = s_tkeep[i*KB +: KB];
          m_tid[o*ID_BITS +: ID_BITS] =
            s_tid[i*ID_BITS +: ID_BITS];
        end
      end
    end
    rel = m_tvalid & m_tready & m_tlast;
  end

  always_comb begin
    drop_d = drop_q;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (st_q[i] == IN_DROP && s_tvalid[i] && s_tlast[i]) begin
        drop_d = drop_d + CNT_BITS'(1);
      end
    end
    for (int unsigned o = 0; o < N_OUT; o++) begin
      pkt_d[o] = rel[o] ? pkt_q[o] + CNT_BITS'(1) : pkt_q[o];
    end
    if (cnt_clr) begin
      drop_d = '0;
      for (int unsigned o = 0; o < N_OUT; o++) begin
        pkt_d[o] = '0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drop_q <= '0;
      for (int unsigned o = 0; o < N_OUT; o++) begin
        pkt_q[o] <= '0;
      end
    end else begin
      drop_q <= drop_d;
      for (int unsigned o = 0; o < N_OUT; o++) begin
        pkt_q[o] <= pkt_d[o];
      end
    end
  end

  always_comb begin
    for (int unsigned o = 0; o < N_OUT; o++) begin
      pkt_cnt[o*CNT_BITS +: CNT_BITS] = pkt_q[o];
    end
  end

  assign drop_cnt = drop_q;

endmodule
